shift_pipe: RTL and testbench

Parametrised, stallable, flushable delay line: WIDTH-bit data with a per-stage valid bit passes through DEPTH register stages written with non-blocking assignment. It is the general successor to the two-flop non-blocking pipeline exercise. It is used wherever the datapath needs a fixed, configurable latency with valid tracking and an occupancy count. An optional tap port reads any intermediate stage.

---
 rtl/shift_pipe_pkg.sv | 12 +
 rtl/shift_pipe_stage.sv | 17 +
 rtl/shift_pipe.sv | 64 ++++++
 tb/tb_shift_pipe.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pipe_pkg.sv
// shift_pipe_pkg: shared constants, clog2 helper and stage record for shift_pipe
package shift_pipe_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
    typedef struct packed {
        logic                 valid;
        logic [DEF_WIDTH-1:0] data;
    } stage_t;
endpackage

// File: rtl/shift_pipe_stage.sv
// shift_pipe_stage: one {valid, data} register with sync reset, flush and enable
module shift_pipe_stage
    import shift_pipe_pkg::*;
#(
    parameter type T = stage_t
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  T     d,
    output T     q
);
    always_ff @(posedge clk)
        if (rst || clr) q <= '0;
        else if (en) q <= d;
endmodule

// File: rtl/shift_pipe.sv
// shift_pipe: stallable, flushable DEPTH-stage delay line with valid tracking and occupancy count.
// Define SHIFT_PIPE_TAP_EN to add the tap_sel/tap_dout stage read port.
module shift_pipe
    import shift_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int CW = clog2_safe(DEPTH + 1)
`ifdef SHIFT_PIPE_TAP_EN
    ,
    localparam int TW = clog2_safe(DEPTH)
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic [CW-1:0]    count
`ifdef SHIFT_PIPE_TAP_EN
    ,
    input  logic [TW-1:0]    tap_sel,
    output logic [WIDTH-1:0] tap_dout
`endif
);
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } rec_t;
    rec_t stg [DEPTH];
    genvar i;
    for (i = 0; i < DEPTH; i++) begin : g_stage
        rec_t d;
        if (i == 0) begin : g_head
            assign d = '{valid: din_valid, data: din};
        end else begin : g_body
            assign d = stg[i-1];
        end
        shift_pipe_stage #(.T(rec_t)) u_stage (
            .clk(clk),
            .rst(rst),
            .clr(clr),
            .en (en),
            .d  (d),
            .q  (stg[i])
        );
    end
    assign dout       = stg[DEPTH-1].data;
    assign dout_valid = stg[DEPTH-1].valid;
    // Occupancy stays within 0..DEPTH, so modular CW-bit arithmetic is exact.
    always_ff @(posedge clk)
        if (rst || clr) count <= '0;
        else if (en) count <= count + CW'(din_valid) - CW'(stg[DEPTH-1].valid);
`ifdef SHIFT_PIPE_TAP_EN
    always_comb begin
        tap_dout = '0;
        for (int k = 0; k < DEPTH; k++)
            if (tap_sel == TW'(k)) tap_dout = stg[k].data;
    end
`endif
endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe: directed self-checking bench for shift_pipe (DEPTH=4, legacy DEPTH=2, optional tap).
module tb_shift_pipe;
    logic       clk = 1'b0;
    logic       rst, en, clr, din_valid;
    logic [7:0] din, dout;
    logic       dout_valid;
    logic [2:0] count;
    logic       l_rst, l_en, l_din, l_dv, l_dout, l_dout_valid;
    logic       l_clr = 1'b0;
    logic [1:0] l_count;
    int         checks = 0;
    int         failures = 0;
    bit         mon_on = 1'b0;
    logic [8:0] m [4];
    logic [2:0] pc;

    always #5 clk = ~clk;

`ifdef SHIFT_PIPE_TAP_EN
    logic [1:0] tap_sel, t3_sel, t3_count;
    logic [7:0] tap_dout, t3_tap, t3_din, t3_dout;
    logic       t3_en, t3_dout_valid;
    shift_pipe #(.WIDTH(8), .DEPTH(4)) u_dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .din(din), .din_valid(din_valid),
        .dout(dout), .dout_valid(dout_valid), .count(count),
        .tap_sel(tap_sel), .tap_dout(tap_dout)
    );
    shift_pipe #(.WIDTH(8), .DEPTH(3)) u_tap3 (
        .clk(clk), .rst(rst), .en(t3_en), .clr(clr), .din(t3_din), .din_valid(1'b1),
        .dout(t3_dout), .dout_valid(t3_dout_valid), .count(t3_count),
        .tap_sel(t3_sel), .tap_dout(t3_tap)
    );
    shift_pipe #(.WIDTH(1), .DEPTH(2)) u_leg (
        .clk(clk), .rst(l_rst), .en(l_en), .clr(l_clr), .din(l_din), .din_valid(l_dv),
        .dout(l_dout), .dout_valid(l_dout_valid), .count(l_count),
        .tap_sel(1'b0), .tap_dout()
    );
`else
    shift_pipe #(.WIDTH(8), .DEPTH(4)) u_dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .din(din), .din_valid(din_valid),
        .dout(dout), .dout_valid(dout_valid), .count(count)
    );
    shift_pipe #(.WIDTH(1), .DEPTH(2)) u_leg (
        .clk(clk), .rst(l_rst), .en(l_en), .clr(l_clr), .din(l_din), .din_valid(l_dv),
        .dout(l_dout), .dout_valid(l_dout_valid), .count(l_count)
    );
`endif

    // Reference model of the main pipe, used for the per-cycle count invariant.
    always @(posedge clk)
        if (rst || clr) begin
            for (int k = 0; k < 4; k++) m[k] <= '0;
        end else if (en) begin
            m[0] <= {din_valid, din};
            for (int k = 1; k < 4; k++) m[k] <= m[k-1];
        end

    always @(negedge clk) begin
        pc = 3'(m[0][8]) + 3'(m[1][8]) + 3'(m[2][8]) + 3'(m[3][8]);
        if (mon_on) begin
            checks++;
            if (count !== pc) begin
                failures++;
                $display("FAIL invariant.count t=%0t: got %0d want %0d", $time, count, pc);
            end
            checks++;
            if (dout_valid !== m[3][8] || (m[3][8] && dout !== m[3][7:0])) begin
                failures++;
                $display("FAIL invariant.dout t=%0t: got %b/%h want %b/%h", $time,
                         dout_valid, dout, m[3][8], m[3][7:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; en = 1'b1; din = 8'hFF; din_valid = 1'b1;
        l_rst = 1'b1; l_en = 1'b0; l_din = 1'b0; l_dv = 1'b0;
`ifdef SHIFT_PIPE_TAP_EN
        tap_sel = 2'd0; t3_sel = 2'd0; t3_en = 1'b0; t3_din = 8'h00;
`endif
        for (int k = 0; k < 2; k++) begin
            tick();
            mon_on = 1'b1;
            checks++;
            if (dout !== 8'h00 || dout_valid !== 1'b0 || count !== 3'd0) begin
                failures++;
                $display("FAIL reset edge %0d: got dout=%h v=%b cnt=%0d want 00/0/0", k, dout, dout_valid, count);
            end
            checks++;
            if (l_dout !== 1'b0 || l_dout_valid !== 1'b0 || l_count !== 2'd0) begin
                failures++;
                $display("FAIL reset.legacy edge %0d: got %b/%b/%0d want 0/0/0", k, l_dout, l_dout_valid, l_count);
            end
        end
        rst = 1'b0; l_rst = 1'b0;
    endtask

    task automatic test_latency();
        logic [2:0] ec [5] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd0};
        logic       ev [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            din = (k == 0) ? 8'hA5 : 8'h00;
            din_valid = (k == 0);
            tick();
            checks++;
            if (count !== ec[k] || dout_valid !== ev[k]) begin
                failures++;
                $display("FAIL latency edge %0d: got cnt=%0d v=%b want cnt=%0d v=%b", k, count, dout_valid, ec[k], ev[k]);
            end
            if (ev[k]) begin
                checks++;
                if (dout !== 8'hA5) begin
                    failures++;
                    $display("FAIL latency.dout edge %0d: got %h want a5", k, dout);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic       et [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [2:0] ec [7] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0};
        logic       ev [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 7; k++) begin
            en = et[k];
            din = (k == 0) ? 8'hA5 : 8'h3C;
            din_valid = (k == 0);
            tick();
            checks++;
            if (count !== ec[k] || dout_valid !== ev[k]) begin
                failures++;
                $display("FAIL stall edge %0d: got cnt=%0d v=%b want cnt=%0d v=%b", k, count, dout_valid, ec[k], ev[k]);
            end
            if (ev[k]) begin
                checks++;
                if (dout !== 8'hA5) begin
                    failures++;
                    $display("FAIL stall.dout edge %0d: got %h want a5", k, dout);
                end
            end
        end
    endtask

    task automatic test_full_flush();
        en = 1'b1; din_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            din = 8'(k + 1);
            tick();
            checks++;
            if (count !== 3'((k < 3) ? k + 1 : 4)) begin
                failures++;
                $display("FAIL full.count edge %0d: got %0d want %0d", k, count, (k < 3) ? k + 1 : 4);
            end
            if (k >= 3) begin
                checks++;
                if (dout_valid !== 1'b1 || dout !== 8'(k - 2)) begin
                    failures++;
                    $display("FAIL full.dout edge %0d: got %b/%h want 1/%h", k, dout_valid, dout, 8'(k - 2));
                end
            end
        end
        clr = 1'b1; din = 8'h06;
        tick();
        checks++;
        if (count !== 3'd0 || dout_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush: got cnt=%0d v=%b want 0/0", count, dout_valid);
        end
        clr = 1'b0; din = 8'h77;
        tick();
        checks++;
        if (count !== 3'd1 || dout_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush.reload: got cnt=%0d v=%b want 1/0", count, dout_valid);
        end
        din_valid = 1'b0;
    endtask

    task automatic test_legacy();
        logic s [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        l_en = 1'b1; l_dv = 1'b1;
        for (int k = 0; k < 6; k++) begin
            l_din = s[k];
            tick();
            checks++;
            if (l_count !== ((k == 0) ? 2'd1 : 2'd2)) begin
                failures++;
                $display("FAIL legacy.count edge %0d: got %0d want %0d", k, l_count, (k == 0) ? 1 : 2);
            end
            if (k == 0) begin
                checks++;
                if (l_dout_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL legacy.valid edge 0: got %b want 0", l_dout_valid);
                end
            end else begin
                checks++;
                if (l_dout_valid !== 1'b1 || l_dout !== s[k-1]) begin
                    failures++;
                    $display("FAIL legacy.dout edge %0d: got %b/%b want 1/%b", k, l_dout_valid, l_dout, s[k-1]);
                end
            end
        end
        l_en = 1'b0;
    endtask

`ifdef SHIFT_PIPE_TAP_EN
    task automatic test_tap();
        logic [7:0] w  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [7:0] e4 [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
        en = 1'b1; din_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            din = w[k];
            t3_din = w[k];
            t3_en = (k < 3);
            tick();
        end
        en = 1'b0; t3_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tap_sel = 2'(k);
            #1;
            checks++;
            if (tap_dout !== e4[k]) begin
                failures++;
                $display("FAIL tap4 sel %0d: got %h want %h", k, tap_dout, e4[k]);
            end
        end
        t3_sel = 2'd0; #1;
        checks++;
        if (t3_tap !== 8'h33) begin
            failures++;
            $display("FAIL tap3 sel 0: got %h want 33", t3_tap);
        end
        t3_sel = 2'd2; #1;
        checks++;
        if (t3_tap !== 8'h11) begin
            failures++;
            $display("FAIL tap3 sel 2: got %h want 11", t3_tap);
        end
        t3_sel = 2'd3; #1;
        checks++;
        if (t3_tap !== 8'h00) begin
            failures++;
            $display("FAIL tap3 sel 3: got %h want 00", t3_tap);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_latency();
        test_stall();
        test_full_flush();
        test_legacy();
`ifdef SHIFT_PIPE_TAP_EN
        test_tap();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
